data_ram_resp: RTL and testbench
================================

// Module: data_ram_resp
// PURPOSE
//  Data-memory responder for the MEM stage's load/store port: accepts word/half/byte requests,
//  inserts a configurable number of wait states, performs the byte-enabled access on an internal
//  word-wide RAM, and returns read data with a one-cycle ack. Raises stall_o to freeze the pipeline
//  until ack. Sits between the MEM stage and the data-side storage.
// PARAMETERS
//  DEPTH_LOG2   10  words of storage = 2**DEPTH_LOG2 (byte address span 4*2**DEPTH_LOG2)
//  WAIT_CYCLES  2   wait states inserted before the access cycle (0..15)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous reset, active-low
//  mem_ce_i     in   1   request valid; held high until mem_ack_o
//  mem_we_i     in   1   1 = store, 0 = load
//  mem_addr_i   in   32  byte address; bits [1:0] ignored (lane choice via mem_sel_i)
//  mem_sel_i    in   4   byte enables; sel[3]=data[31:24] ... sel[0]=data[7:0] (big-endian)
//  mem_data_i   in   32  store data, lane-aligned
//  mem_data_o   out  32  load data, registered, valid with mem_ack_o, held until next ack
//  mem_ack_o    out  1   one-cycle completion pulse
//  mem_err_o    out  1   with ack: address outside storage span
//  stall_o      out  1   pipeline freeze request
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, wait counter=0, mem_data_o=0, mem_ack_o=0, mem_err_o=0.
//    RAM contents not reset. Pending request discarded; no partial write ever occurs.
//  - FSM IDLE -> WAIT -> ACCESS -> IDLE.
//    IDLE: mem_ce_i=1 latches we/addr/sel/data; -> WAIT (cnt=WAIT_CYCLES-1) or ACCESS if WAIT_CYCLES=0.
//    WAIT: cnt decrements each cycle; cnt==0 -> ACCESS.
//    ACCESS: store writes lanes with sel=1; load registers word into mem_data_o;
//            mem_ack_o=1 this cycle only; -> IDLE.
//  - Latency: ack in cycle WAIT_CYCLES+1 after the cycle ce is sampled high in IDLE.
//    Back-to-back requests: one per WAIT_CYCLES+2 cycles (IDLE always lasts >=1 cycle).
//  - Inputs are latched in IDLE; changes to mem_*_i during WAIT/ACCESS are ignored.
//  - mem_ce_i dropped before ack: request still completes (ack, store performed); not aborted.
//  - stall_o = (state==IDLE & mem_ce_i) | (state==WAIT) ; deasserted in the ACCESS/ack cycle.
//  - Out of range: any of addr[31:DEPTH_LOG2+2] nonzero -> no write, mem_data_o=0,
//    mem_err_o=1 with ack; timing identical to a good access.
//  - sel=4'b0000 store: no RAM change, normal ack. Load ignores sel (returns full word);
//    the MEM stage does lane extraction / sign extension.
//  - Store then load of same address: load observes stored data (no forwarding issue; serialised).
// STRUCTURE
//  - defines.v additions: `DataAddrBus 31:0, `DataBus 31:0, `ByteSelBus 3:0,
//    state encodings `DrIdle/`DrWait/`DrAccess (2 bits), `ZeroWord reused.
//  - Sub-module data_ram_array: 4 byte-lane banks, sync write with per-lane enable,
//    sync read; instantiated once. FSM, counter, range check, ack/stall in top.
// TESTING
//  1 Reset mid-WAIT: store 0xDEADBEEF to 0x10, rst low during WAIT -> no ack, later load 0x10 returns
//    prior value (0 after preload), all outputs 0 during reset.
//  2 Word store/load, WAIT_CYCLES=2: store 0x12345678 @0x20 -> ack 3 cycles after ce; load @0x20 ->
//    mem_data_o=0x12345678 with ack; stall_o high exactly 3 cycles per request.
//  3 Byte lanes: word 0x11223344 @0x40, store sel=4'b0100 data 0x00AA0000 -> load returns 0x11AA3344;
//    sel=0000 store -> unchanged.
//  4 Out of range (DEPTH_LOG2=10): load @0x00001000 -> ack with err=1, data 0; store there
//    does not alias to 0x0.
//  5 WAIT_CYCLES=0 back-to-back: 4 loads with ce held high -> ack every 2nd cycle, correct data each.
//  6 Early ce drop: store asserted 1 cycle then ce low -> ack still issued, RAM updated.

Source files
------------

// File: rtl/data_ram_resp_pkg.sv
// Shared encodings, widths and helpers for the data-side memory responder.
// Imported by the responder top and its storage array.
package data_ram_resp_pkg;

    localparam int unsigned DATA_ADDR_W = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned BYTE_SEL_W  = 4;
    localparam int unsigned CNT_W       = 4;

    localparam logic [1:0] DR_IDLE   = 2'd0;
    localparam logic [1:0] DR_WAIT   = 2'd1;
    localparam logic [1:0] DR_ACCESS = 2'd2;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic                   we;
        logic [DATA_ADDR_W-1:0] addr;
        logic [BYTE_SEL_W-1:0]  sel;
        logic [DATA_W-1:0]      data;
    } dr_req_t;

    // True when any address bit above the implemented word span is set.
    function automatic logic addr_out_of_range(input logic [DATA_ADDR_W-1:0] addr,
                                               input int unsigned depth_log2);
        logic [DATA_ADDR_W-1:0] hi;
        hi = addr >> (depth_log2 + 2);
        return hi != '0;
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Word-wide RAM built from four byte-lane banks: per-lane write enables,
// synchronous write and synchronous read (read register holds between reads).
module data_ram_array #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [7:0] bank [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we[lane]) begin
                bank[waddr] <= wdata[8*lane +: 8];
            end
            if (re) begin
                rd_q <= bank[raddr];
            end
        end

        assign rdata[8*lane +: 8] = rd_q;
    end

endmodule

// File: rtl/data_ram_resp.sv
// MEM-stage data memory responder: latches a request, waits WAIT_CYCLES,
// performs the byte-enabled access and acks for one cycle while stalling the pipe.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_ce_i,
    input  logic                   mem_we_i,
    input  logic [DATA_ADDR_W-1:0] mem_addr_i,
    input  logic [BYTE_SEL_W-1:0]  mem_sel_i,
    input  logic [DATA_W-1:0]      mem_data_i,
    output logic [DATA_W-1:0]      mem_data_o,
    output logic                   mem_ack_o,
    output logic                   mem_err_o,
    output logic                   stall_o
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    dr_req_t                req_q;
    logic                   ack_q;
    logic                   err_q;
    logic                   rd_zero_q;

    logic [DATA_ADDR_W-1:0] cur_addr;
    logic                   cur_we;
    logic                   cur_oor;
    logic                   launch;
    logic                   rd_en;
    logic [3:0]             wr_en;
    logic [DATA_W-1:0]      ram_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            DR_IDLE: begin
                if (mem_ce_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = DR_ACCESS;
                    end else begin
                        state_d = DR_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            DR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DR_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DR_ACCESS: state_d = DR_IDLE;
            default:   state_d = DR_IDLE;
        endcase
    end

    // With zero wait states the access launches straight from IDLE, so use live inputs there.
    assign cur_addr = (state_q == DR_IDLE) ? mem_addr_i : req_q.addr;
    assign cur_we   = (state_q == DR_IDLE) ? mem_we_i   : req_q.we;
    assign cur_oor  = addr_out_of_range(cur_addr, DEPTH_LOG2);

    // Sync-read RAM: issue the read on the edge entering ACCESS so data is there with ack.
    assign launch = (state_d == DR_ACCESS);
    assign rd_en  = launch && !cur_we && !cur_oor;

    // Writes land on the edge closing ACCESS; a reset before then leaves RAM untouched.
    assign wr_en = (state_q == DR_ACCESS && req_q.we && !err_q) ? req_q.sel : 4'b0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DR_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= launch;
            err_q   <= launch && cur_oor;
            if (state_q == DR_IDLE && mem_ce_i) begin
                req_q.we   <= mem_we_i;
                req_q.addr <= mem_addr_i;
                req_q.sel  <= mem_sel_i;
                req_q.data <= mem_data_i;
            end
            if (launch && !cur_we) begin
                rd_zero_q <= cur_oor;
            end
        end
    end

    data_ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (req_q.addr[DEPTH_LOG2+1:2]),
        .wdata (req_q.data),
        .re    (rd_en),
        .raddr (cur_addr[DEPTH_LOG2+1:2]),
        .rdata (ram_rdata)
    );

    assign mem_data_o = rd_zero_q ? ZERO_WORD : ram_rdata;
    assign mem_ack_o  = ack_q;
    assign mem_err_o  = err_q;
    assign stall_o    = (state_q == DR_IDLE && mem_ce_i) || (state_q == DR_WAIT);

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: one instance with two wait states, one with none.
module tb_data_ram_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        ce = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  sel = '0;
    logic [31:0] rdata;
    logic        ack, err, stall;

    logic        ce0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [3:0]  sel0 = '0;
    logic [31:0] rdata0;
    logic        ack0, err0, stall0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_ram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_addr_i(addr),
        .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rdata), .mem_ack_o(ack),
        .mem_err_o(err), .stall_o(stall)
    );

    data_ram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_ce_i(ce0), .mem_we_i(we0), .mem_addr_i(addr0),
        .mem_sel_i(sel0), .mem_data_i(wdata0), .mem_data_o(rdata0), .mem_ack_o(ack0),
        .mem_err_o(err0), .stall_o(stall0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Full request on the 2-wait instance; returns ack latency and stall-high cycle count.
    task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output int lat, output int stalls,
                       output logic [31:0] rd, output logic er);
        bit got;
        ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
        #1;
        stalls = int'(stall);
        lat = 0; got = 0; rd = '0; er = 1'b0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(posedge clk); #1;
            stalls += int'(stall);
            if (ack) begin
                got = 1; lat = n; rd = rdata; er = err;
                ce = 1'b0;
            end
        end
        ce = 1'b0;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic req0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat);
        bit got;
        ce0 = 1'b1; we0 = w; addr0 = a; sel0 = 4'hF; wdata0 = d;
        lat = 0; got = 0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(posedge clk); #1;
            if (ack0) begin
                got = 1; lat = n; ce0 = 1'b0;
            end
        end
        ce0 = 1'b0;
        if (!got) check("ack0_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, stalls, any_ack, idx;
        logic [31:0] rd;
        logic er;

        // Reset state
        #12;
        check("rst_data", rdata, 32'h0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // 1: reset during WAIT drops the store
        req(1'b1, 32'h10, 4'hF, 32'h0, lat, stalls, rd, er);
        ce = 1'b1; we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        ce = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_data", rdata, 32'h0);
        any_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            any_ack += int'(ack);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            any_ack += int'(ack);
        end
        check("midrst_noack", 32'(any_ack), 32'd0);
        req(1'b0, 32'h10, 4'hF, 32'h0, lat, stalls, rd, er);
        check("midrst_load", rd, 32'h0);

        // 2: word store/load latency and stall length
        req(1'b1, 32'h20, 4'hF, 32'h12345678, lat, stalls, rd, er);
        check("st_lat", 32'(lat), 32'd3);
        check("st_stall", 32'(stalls), 32'd3);
        req(1'b0, 32'h20, 4'hF, 32'h0, lat, stalls, rd, er);
        check("ld_lat", 32'(lat), 32'd3);
        check("ld_stall", 32'(stalls), 32'd3);
        check("ld_data", rd, 32'h12345678);
        check("ld_err", 32'(er), 32'd0);
        @(posedge clk); #1;
        check("ld_hold", rdata, 32'h12345678);

        // 3: byte lanes
        req(1'b1, 32'h40, 4'hF, 32'h11223344, lat, stalls, rd, er);
        req(1'b1, 32'h40, 4'b0100, 32'h00AA0000, lat, stalls, rd, er);
        req(1'b0, 32'h40, 4'h0, 32'h0, lat, stalls, rd, er);
        check("lane_data", rd, 32'h11AA3344);
        req(1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, lat, stalls, rd, er);
        check("sel0_lat", 32'(lat), 32'd3);
        req(1'b0, 32'h40, 4'hF, 32'h0, lat, stalls, rd, er);
        check("sel0_data", rd, 32'h11AA3344);

        // 4: out of range and top-of-span boundary
        req(1'b1, 32'h0, 4'hF, 32'h0BADC0DE, lat, stalls, rd, er);
        req(1'b0, 32'h1000, 4'hF, 32'h0, lat, stalls, rd, er);
        check("oor_ld_err", 32'(er), 32'd1);
        check("oor_ld_data", rd, 32'h0);
        check("oor_ld_lat", 32'(lat), 32'd3);
        req(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, lat, stalls, rd, er);
        check("oor_st_err", 32'(er), 32'd1);
        req(1'b0, 32'h0, 4'hF, 32'h0, lat, stalls, rd, er);
        check("oor_noalias", rd, 32'h0BADC0DE);
        check("oor_noalias_err", 32'(er), 32'd0);
        req(1'b1, 32'hFFC, 4'hF, 32'hA5A5A5A5, lat, stalls, rd, er);
        req(1'b0, 32'hFFC, 4'hF, 32'h0, lat, stalls, rd, er);
        check("top_word", rd, 32'hA5A5A5A5);
        check("top_err", 32'(er), 32'd0);

        // 6: ce dropped after one cycle still completes
        ce = 1'b1; we = 1'b1; addr = 32'h80; sel = 4'hF; wdata = 32'h55667788;
        @(posedge clk); #1;
        ce = 1'b0; wdata = 32'h0; addr = 32'h84;
        lat = 0;
        for (int n = 2; n <= 20 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (ack) lat = n;
        end
        check("drop_lat", 32'(lat), 32'd3);
        @(posedge clk); #1;
        req(1'b0, 32'h80, 4'hF, 32'h0, lat, stalls, rd, er);
        check("drop_data", rd, 32'h55667788);

        // 5: zero wait states, back-to-back loads with ce held high
        for (int i = 0; i < 4; i++) begin
            req0(1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i), lat);
            if (i == 0) check("w0_st_lat", 32'(lat), 32'd1);
        end
        idx = 0;
        ce0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(posedge clk); #1;
            check($sformatf("w0_ack_c%0d", cyc), 32'(ack0), 32'(cyc % 2));
            if (ack0) begin
                check($sformatf("w0_data_%0d", idx), rdata0, 32'hC0DE0000 + 32'(idx));
                idx++;
                addr0 = 32'(idx * 4);
                if (idx == 4) ce0 = 1'b0;
            end
        end
        check("w0_count", 32'(idx), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
